mem_access_stage: RTL

- MEM stage of the 5-stage 64-bit pipeline; sits directly upstream of write-back.
- Takes the EX/MEM bundle, performs doubleword load/store over a ready/ack data-memory port, and holds the MEM/WB register.
- Its registered outputs (Reg, LoadedData, Results, MemToReg, RegWrite) drive write-back directly.
- Raises Stall toward earlier stages while a memory transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/dmem_handshake.sv | 101 ++++++++++
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its data-memory handshake.
package mem_stage_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int REG_W_DEF  = 5;

    // Low address bits that must be zero for a doubleword access.
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [REG_W_DEF-1:0]  rd;
        logic [DATA_W_DEF-1:0] result;
        logic [DATA_W_DEF-1:0] store_data;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
    } ex_mem_t;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request/ack handshake: holds one outstanding request and aborts it
// if no ack arrives within TIMEOUT cycles.
//
//   state | meaning
//   IDLE  | no request outstanding; start launches one
//   WAIT  | MemReq held stable until ack or timeout abort
module dmem_handshake
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            WAIT: begin
                // An ack on the final counted cycle still completes normally.
                if (mem_ack || cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == WAIT);
        done    = (state_q == WAIT) && mem_ack;
        aborted = (state_q == WAIT) && !mem_ack && (cnt_q == CNT_LAST);
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = mem_rdata;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: doubleword load/store through dmem_handshake and the MEM/WB
// register feeding write-back.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InValid,
    input  logic [REG_W-1:0]  InReg,
    input  logic [DATA_W-1:0] InResult,
    input  logic [DATA_W-1:0] InStoreData,
    input  logic              InMemRead,
    input  logic              InMemWrite,
    input  logic              InMemToReg,
    input  logic              InRegWrite,
    input  logic              Flush,
    output logic              Stall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic [REG_W-1:0]  Reg,
    output logic [DATA_W-1:0] LoadedData,
    output logic [DATA_W-1:0] Results,
    output logic              MemToReg,
    output logic              RegWrite,
    output logic              MisalignFault,
    output logic              BusError
);

    ex_mem_t           in_b;
    logic              busy, done, aborted, start;
    logic              is_mem, misaligned, accept;
    logic [DATA_W-1:0] rdata;

    logic [REG_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0] loaded_q, loaded_d;
    logic [DATA_W-1:0] results_q, results_d;
    logic              m2r_q, m2r_d;
    logic              rw_q, rw_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic [REG_W-1:0]  pend_rd_q, pend_rd_d;
    logic [DATA_W-1:0] pend_res_q, pend_res_d;
    logic              pend_load_q, pend_load_d;
    logic              pend_m2r_q, pend_m2r_d;
    logic              pend_rw_q, pend_rw_d;
    logic              squash_q, squash_d;

    always_comb begin
        in_b.rd         = InReg;
        in_b.result     = InResult;
        in_b.store_data = InStoreData;
        in_b.mem_read   = InMemRead;
        in_b.mem_write  = InMemWrite;
        in_b.mem_to_reg = InMemToReg;
        in_b.reg_write  = InRegWrite;
    end

    assign is_mem     = in_b.mem_read || in_b.mem_write;
    assign misaligned = |(in_b.result[2:0] & ALIGN_MASK);
    assign accept     = !busy && InValid && !Flush;
    assign start      = accept && is_mem && !misaligned;

    dmem_handshake #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .we        (in_b.mem_write),
        .addr      (in_b.result),
        .wdata     (in_b.store_data),
        .mem_ack   (MemAck),
        .mem_rdata (MemRData),
        .mem_req   (MemReq),
        .mem_we    (MemWe),
        .mem_addr  (MemAddr),
        .mem_wdata (MemWData),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .rdata     (rdata)
    );

    always_comb begin
        reg_d       = reg_q;
        loaded_d    = loaded_q;
        results_d   = results_q;
        m2r_d       = m2r_q;
        rw_d        = 1'b0;
        mis_d       = 1'b0;
        berr_d      = 1'b0;
        pend_rd_d   = pend_rd_q;
        pend_res_d  = pend_res_q;
        pend_load_d = pend_load_q;
        pend_m2r_d  = pend_m2r_q;
        pend_rw_d   = pend_rw_q;
        squash_d    = squash_q;
        if (!busy) begin
            squash_d = 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    reg_d     = in_b.rd;
                    results_d = in_b.result;
                    m2r_d     = in_b.mem_to_reg;
                    rw_d      = in_b.reg_write;
                end else if (misaligned) begin
                    mis_d = 1'b1;
                end else begin
                    pend_rd_d   = in_b.rd;
                    pend_res_d  = in_b.result;
                    pend_load_d = in_b.mem_read && !in_b.mem_write;
                    pend_m2r_d  = in_b.mem_to_reg;
                    pend_rw_d   = in_b.reg_write;
                end
            end
        end else begin
            if (Flush) begin
                squash_d = 1'b1;
            end
            // A squashed transaction still completes on the bus but retires as a bubble.
            if (done) begin
                squash_d = 1'b0;
                if (!(squash_q || Flush)) begin
                    reg_d     = pend_rd_q;
                    results_d = pend_res_q;
                    m2r_d     = pend_m2r_q;
                    rw_d      = pend_rw_q;
                    if (pend_load_q) begin
                        loaded_d = rdata;
                    end
                end
            end else if (aborted) begin
                squash_d = 1'b0;
                berr_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q       <= '0;
            loaded_q    <= '0;
            results_q   <= '0;
            m2r_q       <= 1'b0;
            rw_q        <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
            pend_rd_q   <= '0;
            pend_res_q  <= '0;
            pend_load_q <= 1'b0;
            pend_m2r_q  <= 1'b0;
            pend_rw_q   <= 1'b0;
            squash_q    <= 1'b0;
        end else begin
            reg_q       <= reg_d;
            loaded_q    <= loaded_d;
            results_q   <= results_d;
            m2r_q       <= m2r_d;
            rw_q        <= rw_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
            pend_rd_q   <= pend_rd_d;
            pend_res_q  <= pend_res_d;
            pend_load_q <= pend_load_d;
            pend_m2r_q  <= pend_m2r_d;
            pend_rw_q   <= pend_rw_d;
            squash_q    <= squash_d;
        end
    end

    assign Stall         = busy;
    assign Reg           = reg_q;
    assign LoadedData    = loaded_q;
    assign Results       = results_q;
    assign MemToReg      = m2r_q;
    assign RegWrite      = rw_q;
    assign MisalignFault = mis_q;
    assign BusError      = berr_q;

endmodule
